// File: rtl/wb_regfile.sv
// wb_regfile: MIPS writeback stage plus 32x32 architectural register file.
//
// Selects the write-back destination and value from the MEM/WB pipeline
// register. Commits the value on the rising clock edge. Serves two
// combinational ID read ports, with a same-cycle bypass of the pending write.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   instructionin     MEM/WB instruction (rt = [20:16], rd = [15:11])
//   PCplusin          MEM/WB PC+4
//   rdatain           MEM/WB data-memory read data
//   ALUresultin       MEM/WB ALU result
//   RegDstin          destination select: 00 rt, 01 rd, 10 $31, 11 $26
//   RegWrin           register write enable
//   MemtoRegin        data select: 00 ALU, 01 mem, 10 PC+4, 11 PC+4-4
//   rs_addr/rt_addr   ID read port addresses
//   rs_data/rt_data   ID read port data (combinational, bypassed)
//   wb_en/addr/data   current writeback, for forwarding (combinational)
//   wb_count          committed writes since reset (registered)
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_03FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instructionin,
    input  logic [31:0] PCplusin,
    input  logic [31:0] rdatain,
    input  logic [31:0] ALUresultin,
    input  logic [1:0]  RegDstin,
    input  logic        RegWrin,
    input  logic [1:0]  MemtoRegin,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] wb_count
);

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 5;
    localparam int unsigned NREG    = 32;
    localparam int unsigned SP_IDX  = 29;
    localparam logic [AW-1:0] RA_IDX = AW'(31);
    localparam logic [AW-1:0] K0_IDX = AW'(26);

    // $0 has no storage, so the array starts at index 1.
    logic [DW-1:0] regs_q [1:NREG-1];
    logic [DW-1:0] regs_d [1:NREG-1];
    logic [DW-1:0] count_q;
    logic [DW-1:0] count_d;

    // Destination decode.
    always_comb begin
        wb_addr = '0;
        case (RegDstin)
            2'b00:   wb_addr = instructionin[20:16];
            2'b01:   wb_addr = instructionin[15:11];
            2'b10:   wb_addr = RA_IDX;
            default: wb_addr = K0_IDX;
        endcase
    end

    // Write-back value select. Code 11 is the return address of an
    // exception, which is PC+4 minus 4. It wraps modulo 2^32.
    always_comb begin
        wb_data = '0;
        case (MemtoRegin)
            2'b00:   wb_data = ALUresultin;
            2'b01:   wb_data = rdatain;
            2'b10:   wb_data = PCplusin;
            default: wb_data = PCplusin - DW'(4);
        endcase
    end

    // A write commits only to a real register, and only outside reset.
    assign wb_en = RegWrin & (wb_addr != '0) & ~reset;

    // Next state for the register file and the retired-write counter.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        count_d = count_q;
        if (wb_en) begin
            for (int i = 1; i < NREG; i++) begin
                if (wb_addr == AW'(i)) begin
                    regs_d[i] = wb_data;
                end
            end
            count_d = count_q + DW'(1);
        end
    end

    // State registers. Reset has priority over any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            count_q <= count_d;
        end
    end

    // Read port A: $0 is hardwired to zero; the pending write bypasses stored state.
    always_comb begin
        rs_data = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs_addr == AW'(i)) begin
                rs_data = regs_q[i];
            end
        end
        if (wb_en && (rs_addr == wb_addr)) begin
            rs_data = wb_data;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        rt_data = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rt_addr == AW'(i)) begin
                rt_data = regs_q[i];
            end
        end
        if (wb_en && (rt_addr == wb_addr)) begin
            rt_data = wb_data;
        end
    end

    assign wb_count = count_q;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the pipelined MIPS core. Consumes the MEM/WB pipeline register outputs, selects the write-back value and destination, and commits it to a 32×32 register file on the rising clock edge. Serves the ID stage's two combinational read ports with an internal write-before-read bypass. Exports the current writeback for forwarding, plus a retired-write counter.

## Interface
- SP_INIT, 32'h0000_03FC, reset value of $29 ($sp)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instructionin  in  32  MEM/WB instruction; rt=[20:16], rd=[15:11]
- PCplusin  in  32  MEM/WB PC+4
- rdatain  in  32  MEM/WB data-memory read data
- ALUresultin  in  32  MEM/WB ALU result
- RegDstin  in  2  destination select: 00 rt, 01 rd, 10 $31, 11 $26 ($k0)
- RegWrin  in  1  register write enable
- MemtoRegin  in  2  data select: 00 ALUresultin, 01 rdatain, 10 PCplusin, 11 PCplusin-4
- rs_addr  in  5  ID read port A address
- rt_addr  in  5  ID read port B address
- rs_data  out  32  read port A data (combinational)
- rt_data  out  32  read port B data (combinational)
- wb_en  out  1  this cycle commits a write (RegWrin and wb_addr≠0, not in reset)
- wb_addr  out  5  decoded destination register
- wb_data  out  32  selected write-back value
- wb_count  out  32  number of committed writes since reset

## Operation
- wb_addr decoded combinationally from RegDstin/instructionin; wb_data from MemtoRegin mux. Code 11 uses PCplusin − 32'd4, modulo 2^32 (PCplusin=0 → 32'hFFFF_FFFC).
- wb_en = RegWrin & (wb_addr≠5'd0) & ~reset.
- Rising edge, reset=1: regs $1..$28, $30, $31 ← 0; $29 ← SP_INIT; wb_count ← 0. Inputs ignored.
- Rising edge, reset=0, wb_en=1: reg[wb_addr] ← wb_data; wb_count ← wb_count+1 (wraps FFFF_FFFF → 0).
- Rising edge, wb_en=0: no register or counter change.
- $0 has no storage; always reads 0; writes to $0 discarded and not counted.
- Read ports: addr=0 → 0; else if wb_en and addr==wb_addr → wb_data (bypass); else reg[addr]. Both ports may hit the same register and/or the bypass simultaneously.
- Unknown/illegal instruction fields are not checked; selection is purely by RegDstin/MemtoRegin.

## Timing
- Write latency: value committed at edge N is visible from stored state after edge N; via bypass it is visible combinationally during cycle N itself (zero-cycle read-after-write for ID).
- Read ports, wb_* outputs: purely combinational, no registered delay.
- wb_count: registered; reflects writes committed up to the last edge.
- Reset values: all registers 0 except $29 = SP_INIT; wb_count = 0; wb_en = 0 while reset high. rs_data/rt_data during reset reflect stored state (no bypass).
- Reset asserted mid-stream: pending MEM/WB write in that cycle is dropped and not counted; reset wins over wb_en.
- Back-to-back writes to the same register: last edge wins; no stall or hazard logic in this block.

## Test plan
- Reset: hold reset 2 cycles, release -> every read port returns 0 except rs_addr=29 returns 32'h0000_03FC; wb_count=0.
- R-type commit: RegDstin=01, rd=5, MemtoRegin=00, ALUresultin=32'h1234_5678, RegWrin=1 -> same cycle rs_addr=5 reads 32'h1234_5678 (bypass); next cycle with RegWrin=0 still reads it; wb_count=1.
- Load/jal/exception: lw (RegDstin=00, rt=8, MemtoRegin=01, rdatain=32'hDEAD_BEEF) -> $8=DEAD_BEEF; jal (RegDstin=10, MemtoRegin=10, PCplusin=32'h0000_0044) -> $31=0000_0044; exception (RegDstin=11, MemtoRegin=11, PCplusin=32'h0000_0080) -> $26=0000_007C; wb_count=3.
- $0 protection: RegWrin=1, rd=0, ALUresultin=32'hFFFF_FFFF -> wb_en=0, rs_addr=0 reads 0, wb_count unchanged.
- Reset mid-write: reset=1 with RegWrin=1, rd=9, value 32'hAAAA_AAAA -> $9 reads 0 after edge, wb_count=0.
- Counter/wrap: force 2^32 committed writes (or preload via long run in simulation) -> wb_count wraps to 0; PCplusin=0 with MemtoRegin=11 writes 32'hFFFF_FFFC.
